// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the memory controller and its two clients
// (instruction fetch and the load/store buffer).
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_read_signal;
  logic        lsb_write_signal;
  logic [2:0]  requiring_length;
  logic [31:0] to_mem_addr;
  logic [31:0] to_mem_data;
  logic        load_signed;
  logic        mem_load_success;
  logic [31:0] from_mem_data;
  logic        mem_store_done;

  // Client side: raises requests, observes completions.
  modport master (
    output if_req, if_addr, lsb_read_signal, lsb_write_signal,
           requiring_length, to_mem_addr, to_mem_data, load_signed,
    input  if_done, if_data, mem_load_success, from_mem_data, mem_store_done
  );

  // Controller side: serves requests, reports completions.
  modport slave (
    input  if_req, if_addr, lsb_read_signal, lsb_write_signal,
           requiring_length, to_mem_addr, to_mem_data, load_signed,
    output if_done, if_data, mem_load_success, from_mem_data, mem_store_done
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating between instruction fetch and the
// load/store buffer; assembles little-endian words and stalls writes to a full
// I/O buffer.
module mem_ctrl #(
  parameter logic [1:0] IO_MASK_HI = 2'b11,
  parameter int         RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        jump_wrong_i,
  input  logic        io_buffer_full_i,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  mem_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        lastGrant_q, lastGrant_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sext_q, sext_d;

  logic        isRead;
  logic        capture;
  logic        readDone;
  logic        ioStall;
  logic        lsbReq;
  logic [1:0]  rdIdx;
  logic [1:0]  wrIdx;
  logic [31:0] rdWord;
  logic [31:0] loadExt;

  // Merge the byte currently returned by the RAM into the word being assembled;
  // the byte addressed LAT cycles ago lands in its little-endian lane.
  always_comb begin
    isRead   = (state_q == FETCH) || (state_q == LOAD);
    rdIdx    = 2'(cnt_q - LAT);
    capture  = isRead && (cnt_q >= LAT) && ((cnt_q - LAT) < len_q);
    readDone = isRead && (cnt_q == len_q + LAT - 3'd1);
    rdWord   = rdata_q;
    if (capture) begin
      rdWord[{rdIdx, 3'b000} +: 8] = mem_din_i;
    end
  end

  // Sub-word loads are sign- or zero-extended from their top byte lane.
  always_comb begin
    loadExt = rdWord;
    case (len_q)
      3'd1:    loadExt = {{24{sext_q & rdWord[7]}}, rdWord[7:0]};
      3'd2:    loadExt = {{16{sext_q & rdWord[15]}}, rdWord[15:0]};
      default: loadExt = rdWord;
    endcase
  end

  // Next-state and output logic: arbitration, byte sequencing, I/O stall and flush.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    base_d      = base_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sext_d      = sext_q;

    lsbReq     = bus.lsb_read_signal | bus.lsb_write_signal;
    wrIdx      = cnt_q[1:0];
    mem_a_o    = (state_q == IDLE) ? 32'h0 : base_q + {29'h0, cnt_q};
    mem_dout_o = 8'h00;
    mem_wr_o   = 1'b0;
    ioStall    = 1'b0;

    bus.if_done          = 1'b0;
    bus.mem_load_success = 1'b0;
    bus.mem_store_done   = 1'b0;
    bus.if_data          = rdWord;
    bus.from_mem_data    = loadExt;

    if (state_q == STORE && cnt_q < len_q) begin
      mem_dout_o = wdata_q[{wrIdx, 3'b000} +: 8];
      ioStall    = (mem_a_o[17:16] == IO_MASK_HI) && io_buffer_full_i;
      mem_wr_o   = rdy_i && !ioStall;
    end

    if (rdy_i) begin
      case (state_q)
        IDLE: begin
          if (!jump_wrong_i) begin
            if (bus.if_req && (!lsbReq || lastGrant_q)) begin
              state_d     = FETCH;
              base_d      = bus.if_addr;
              len_d       = 3'd4;
              rdata_d     = 32'h0;
              cnt_d       = 3'd0;
              lastGrant_d = 1'b0;
            end else if (lsbReq) begin
              state_d     = bus.lsb_write_signal ? STORE : LOAD;
              base_d      = bus.to_mem_addr;
              len_d       = bus.requiring_length;
              wdata_d     = bus.to_mem_data;
              sext_d      = bus.load_signed;
              rdata_d     = 32'h0;
              cnt_d       = 3'd0;
              lastGrant_d = 1'b1;
            end
          end
        end
        FETCH, LOAD: begin
          if (jump_wrong_i) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else if (readDone) begin
            bus.if_done          = (state_q == FETCH);
            bus.mem_load_success = (state_q == LOAD);
            rdata_d              = rdWord;
            state_d              = IDLE;
            cnt_d                = 3'd0;
          end else begin
            rdata_d = rdWord;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        STORE: begin
          if (cnt_q == len_q) begin
            bus.mem_store_done = 1'b1;
            state_d            = IDLE;
            cnt_d              = 3'd0;
          end else if (!ioStall) begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset abandons any transfer and favours fetch on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      lastGrant_q <= 1'b1;
      base_q      <= 32'h0;
      len_q       <= 3'd0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      sext_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      base_q      <= base_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sext_q      <= sext_d;
    end
  end
endmodule
